truth_table_sequencer: RTL and testbench

- Self-checking exhaustive-stimulus controller for the lab's 4-input combinational experiment block.
- Drives every input combination A,B,C,D (0000..1111) in ascending order and waits a settle time. Then samples the DUT's output bundle (F1,F2,DUALITY,F3,NOTF3,F4) and compares it against a parameterised expected truth table.
- Instantiated between the board switches/buttons and the experiment block. Replaces the manual 16-step stimulus with an on-chip pass/fail check.

---
 rtl/truth_table_sequencer.sv | 146 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Exhaustive-stimulus controller: sweeps every NIN-bit input vector, samples the
// experiment block's outputs and scores them against the EXPECTED truth table.
// Optional macro SEQ_STEP_EN adds a STEP input and a HOLD state for manual per-vector advance.
module truth_table_sequencer #(
  parameter int NIN           = 4,
  parameter int NOUT          = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [(2**NIN)*NOUT-1:0] EXPECTED = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            ABORT,
`ifdef SEQ_STEP_EN
  input  logic            STEP,
`endif
  input  logic [NOUT-1:0] DUT_OUT,
  output logic [NIN-1:0]  VEC,
  output logic            BUSY,
  output logic            DONE,
  output logic            RESULT_VALID,
  output logic            PASS,
  output logic [NIN:0]    ERR_COUNT,
  output logic [NIN-1:0]  FIRST_FAIL
);

  localparam logic [7:0]     RELOAD   = 8'(SETTLE_CYCLES - 1);
  localparam logic [NIN-1:0] LAST_VEC = {NIN{1'b1}};
  localparam logic [NIN:0]   ERR_MAX  = {1'b1, {NIN{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH,
    S_HOLD
  } state_t;

  state_t         r_state;
  logic [7:0]     r_cnt;
  logic [NIN-1:0] r_vec;
  logic           r_busy;
  logic           r_done;
  logic           r_valid;
  logic           r_pass;
  logic [NIN:0]   r_err;
  logic [NIN-1:0] r_first;

  logic [NOUT-1:0] w_expected;
  logic            w_mismatch;

  function automatic logic [NIN:0] sat_inc(input logic [NIN:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  assign w_expected = EXPECTED[int'(r_vec)*NOUT +: NOUT];
  assign w_mismatch = (DUT_OUT != w_expected);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      r_done <= 1'b0;
      // ABORT pre-empts every transition; partial error statistics are kept
      if (ABORT && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_vec   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (START && !ABORT) begin
              r_vec   <= '0;
              r_err   <= '0;
              r_first <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b1;
              r_cnt   <= RELOAD;
              r_state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_cnt == 8'd0) r_state <= S_SAMPLE;
            else               r_cnt   <= r_cnt - 8'd1;
          end
          S_SAMPLE: begin
            if (w_mismatch) begin
              r_err <= sat_inc(r_err);
              if (r_err == '0) r_first <= r_vec;
            end
`ifdef SEQ_STEP_EN
            r_state <= S_HOLD;
`else
            if (r_vec == LAST_VEC) begin
              r_state <= S_FINISH;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_cnt   <= RELOAD;
              r_state <= S_SETTLE;
            end
`endif
          end
`ifdef SEQ_STEP_EN
          S_HOLD: begin
            if (STEP) begin
              if (r_vec == LAST_VEC) begin
                r_state <= S_FINISH;
              end else begin
                r_vec   <= r_vec + 1'b1;
                r_cnt   <= RELOAD;
                r_state <= S_SETTLE;
              end
            end
          end
`endif
          S_FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_pass  <= (r_err == '0);
            r_vec   <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign VEC          = r_vec;
  assign BUSY         = r_busy;
  assign DONE         = r_done;
  assign RESULT_VALID = r_valid;
  assign PASS         = r_pass;
  assign ERR_COUNT    = r_err;
  assign FIRST_FAIL   = r_first;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: per-sweep expected results are queued at START
// and popped by a monitor on DONE; a sequence monitor tracks VEC against elapsed cycles.
module tb_truth_table_sequencer;
  localparam int NIN  = 4;
  localparam int NOUT = 6;
  localparam int SET  = 4;
  localparam int NVEC = 16;
`ifdef SEQ_STEP_EN
  localparam int VEC_CYC = SET + 2;
`else
  localparam int VEC_CYC = SET + 1;
`endif
  localparam int DONE_LAT = NVEC * VEC_CYC + 1;
  localparam logic [NVEC*NOUT-1:0] GOLD = 96'h3A5C_960F_1E2D_784B_1C52_E9D3;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            START;
  logic            ABORT;
`ifdef SEQ_STEP_EN
  logic            STEP;
`endif
  logic [NOUT-1:0] DUT_OUT;
  logic [NIN-1:0]  VEC;
  logic            BUSY;
  logic            DONE;
  logic            RESULT_VALID;
  logic            PASS;
  logic [NIN:0]    ERR_COUNT;
  logic [NIN-1:0]  FIRST_FAIL;

  logic [NOUT-1:0] gold [NVEC];
  logic [NOUT-1:0] tbl  [NVEC];

  typedef struct {
    logic pass;
    int   err;
    int   ff;
    int   done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t part;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   sw_start = -1;
  int   mon_k;

  truth_table_sequencer #(
    .NIN(NIN), .NOUT(NOUT), .SETTLE_CYCLES(SET), .EXPECTED(GOLD)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
`ifdef SEQ_STEP_EN
    .STEP(STEP),
`endif
    .DUT_OUT(DUT_OUT), .VEC(VEC), .BUSY(BUSY), .DONE(DONE),
    .RESULT_VALID(RESULT_VALID), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
    .FIRST_FAIL(FIRST_FAIL)
  );

  assign DUT_OUT = tbl[VEC];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: score the first 'upto' vectors of the driven table against the golden table.
  function automatic exp_t model(input int upto);
    exp_t e;
    e.err = 0;
    e.ff = 0;
    for (int i = 0; i < upto; i++) begin
      if (tbl[i] !== gold[i]) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    e.done_cyc = -1;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (sw_start >= 0) begin
      mon_k = cyc - sw_start;
      if (mon_k < NVEC * VEC_CYC) check("vec_seq", int'(VEC), mon_k / VEC_CYC);
      else sw_start = -1;
    end
    if (DONE) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pass", int'(PASS), int'(mon_e.pass));
        check("err_count", int'(ERR_COUNT), mon_e.err);
        check("first_fail", int'(FIRST_FAIL), mon_e.ff);
        check("result_valid", int'(RESULT_VALID), 1);
        check("busy_at_done", int'(BUSY), 0);
        if (mon_e.done_cyc >= 0) check("done_latency", cyc, mon_e.done_cyc);
      end
    end
  end

  task automatic set_golden();
    for (int i = 0; i < NVEC; i++) tbl[i] = gold[i];
  endtask

  task automatic start_sweep(input bit arm);
    exp_t e;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", int'(BUSY), 1);
    check("rv_clear_after_start", int'(RESULT_VALID), 0);
    e = model(NVEC);
    e.done_cyc = arm ? cyc + DONE_LAT : -1;
    if (arm) sw_start = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0) return;
      @(negedge CLK);
    end
    if (sb.size() != 0) begin
      check("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic wait_vec(input int v);
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (int'(VEC) == v && BUSY) return;
    end
    check("wait_vec_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
`ifdef SEQ_STEP_EN
    STEP = 1'b1;
`endif
    for (int i = 0; i < NVEC; i++) gold[i] = GOLD[i*NOUT +: NOUT];
    set_golden();
    #12;
    check("rst_vec", int'(VEC), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_rv", int'(RESULT_VALID), 0);
    check("rst_pass", int'(PASS), 0);
    check("rst_err", int'(ERR_COUNT), 0);
    check("rst_ff", int'(FIRST_FAIL), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // matching table
    start_sweep(1);
    wait_done(DONE_LAT + 20);
    repeat (3) @(negedge CLK);
    check("rv_hold", int'(RESULT_VALID), 1);
    check("pass_hold", int'(PASS), 1);

    // F2 flipped at vectors 5 and 12
    set_golden();
    tbl[5][1]  = ~tbl[5][1];
    tbl[12][1] = ~tbl[12][1];
    start_sweep(1);
    wait_done(DONE_LAT + 20);

    // every entry inverted
    for (int i = 0; i < NVEC; i++) tbl[i] = ~gold[i];
    start_sweep(1);
    wait_done(DONE_LAT + 20);

    // START during a running sweep is ignored
    set_golden();
    start_sweep(1);
    wait_vec(7);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(DONE_LAT + 20);

    // ABORT at vector 9 with mismatches at 2, 6, 11
    set_golden();
    tbl[2]  = ~gold[2];
    tbl[6]  = gold[6] ^ 6'h21;
    tbl[11] = gold[11] ^ 6'h04;
    start_sweep(1);
    wait_vec(9);
    ABORT = 1'b1;
    sw_start = -1;
    sb.delete();
    part = model(9);
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_busy", int'(BUSY), 0);
    check("abort_vec", int'(VEC), 0);
    check("abort_rv", int'(RESULT_VALID), 0);
    check("abort_err", int'(ERR_COUNT), part.err);
    check("abort_ff", int'(FIRST_FAIL), part.ff);
    repeat (100) @(negedge CLK);
    check("abort_no_done_rv", int'(RESULT_VALID), 0);
    set_golden();
    start_sweep(1);
    wait_done(DONE_LAT + 20);

    // ABORT and START together in IDLE: START dropped
    @(negedge CLK);
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    check("abort_start_busy", int'(BUSY), 0);
    check("abort_start_rv", int'(RESULT_VALID), 1);

    // randomized tables
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NVEC; i++)
        tbl[i] = ($urandom_range(3) == 0) ? gold[i] ^ 6'($urandom_range(63, 1)) : gold[i];
      start_sweep(1);
      wait_done(DONE_LAT + 20);
    end

    // asynchronous reset mid-SETTLE at vector 3
    set_golden();
    tbl[0] = ~gold[0];
    start_sweep(1);
    wait_vec(3);
    sw_start = -1;
    sb.delete();
    check("pre_reset_err", int'(ERR_COUNT), 1);
    #1 RESET = 1'b1;
    #1;
    check("async_vec", int'(VEC), 0);
    check("async_busy", int'(BUSY), 0);
    check("async_done", int'(DONE), 0);
    check("async_rv", int'(RESULT_VALID), 0);
    check("async_pass", int'(PASS), 0);
    check("async_err", int'(ERR_COUNT), 0);
    check("async_ff", int'(FIRST_FAIL), 0);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

`ifdef SEQ_STEP_EN
    // manual stepping
    STEP = 1'b0;
    tbl[0] = gold[0];
    tbl[4] = ~gold[4];
    start_sweep(0);
    repeat (40) @(negedge CLK);
    check("step_hold_vec", int'(VEC), 0);
    check("step_hold_busy", int'(BUSY), 1);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      STEP = 1'b1;
      @(negedge CLK);
      STEP = 1'b0;
      repeat (8) @(negedge CLK);
      if (i < NVEC - 1) check("step_vec", int'(VEC), i + 1);
    end
    wait_done(20);
    STEP = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
